adder16_rr_sched: RTL and testbench

Round-robin scheduler that shares one 16-bit adder (`IN1 + IN2`, wrap-around) among `N_REQ` requesters. The arbitration, operand capture, result registration and output handshake are sequenced by a three-state FSM. It sits between several producer blocks and a single downstream consumer. Each completed addition is returned with the ID of the requester that issued it.

---
 rtl/adder16_rr_sched.sv | 132 +++++++++++++
 tb/tb_adder16_rr_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/adder16_rr_sched.sv
// adder16_rr_sched: one WIDTH-bit adder shared round-robin among N_REQ
// requesters, with a registered, ID-tagged result and valid/ready output.
//
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   REQ[N_REQ]          per-requester pending flags
//   REQ_IN1/REQ_IN2     packed operands, slice i = [i*WIDTH +: WIDTH]
//   GNT[N_REQ]          one-hot, one-cycle grant (operands captured)
//   OUT, OUT_CARRY      registered sum (mod 2^WIDTH) and its carry-out
//   OUT_ID              requester that owns OUT
//   OUT_VALID/OUT_READY result handshake toward the consumer
//   BUSY                high whenever the FSM is not in IDLE

module adder16_rr_sched #(
    parameter int WIDTH = 16,
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] REQ_IN1,
    input  logic [N_REQ*WIDTH-1:0] REQ_IN2,
    output logic [N_REQ-1:0]       GNT,
    output logic [WIDTH-1:0]       OUT,
    output logic                   OUT_CARRY,
    output logic [IDW-1:0]         OUT_ID,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   BUSY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   opa, opa_n;
    logic [WIDTH-1:0]   opb, opb_n;
    logic [IDW-1:0]     last, last_n;
    logic [N_REQ-1:0]   gnt_n;
    logic [WIDTH-1:0]   out_n;
    logic               carry_n;
    logic [IDW-1:0]     id_n;
    logic               valid_n;

    logic [IDW-1:0]     win;
    logic               found;

    // Search starts one past the last winner so the previous winner
    // ends up with the lowest priority.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(last) + k) % N_REQ;
            if (!found && REQ[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_n = state;
        opa_n   = opa;
        opb_n   = opb;
        last_n  = last;
        gnt_n   = '0;
        out_n   = OUT;
        carry_n = OUT_CARRY;
        id_n    = OUT_ID;
        valid_n = OUT_VALID;
        unique case (state)
            IDLE: begin
                if (found) begin
                    opa_n      = REQ_IN1[win*WIDTH +: WIDTH];
                    opb_n      = REQ_IN2[win*WIDTH +: WIDTH];
                    gnt_n[win] = 1'b1;
                    last_n     = win;
                    id_n       = win;
                    state_n    = GRANT;
                end
            end
            GRANT: begin
                {carry_n, out_n} = {1'b0, opa} + {1'b0, opb};
                valid_n = 1'b1;
                state_n = RESULT;
            end
            RESULT: begin
                if (OUT_READY) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            opa       <= '0;
            opb       <= '0;
            last      <= IDW'(N_REQ - 1);
            GNT       <= '0;
            OUT       <= '0;
            OUT_CARRY <= 1'b0;
            OUT_ID    <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            state     <= state_n;
            opa       <= opa_n;
            opb       <= opb_n;
            last      <= last_n;
            GNT       <= gnt_n;
            OUT       <= out_n;
            OUT_CARRY <= carry_n;
            OUT_ID    <= id_n;
            OUT_VALID <= valid_n;
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_adder16_rr_sched.sv
// tb_adder16_rr_sched: directed self-checking bench for adder16_rr_sched.
// Inputs change and outputs are sampled 1ns after each rising edge.

module tb_adder16_rr_sched;

    localparam int W = 16;
    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   REQ;
    logic [N*W-1:0] REQ_IN1;
    logic [N*W-1:0] REQ_IN2;
    logic [N-1:0]   GNT;
    logic [W-1:0]   OUT;
    logic           OUT_CARRY;
    logic [1:0]     OUT_ID;
    logic           OUT_VALID;
    logic           OUT_READY;
    logic           BUSY;

    int errors = 0;
    int checks = 0;

    adder16_rr_sched dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .REQ_IN1   (REQ_IN1),
        .REQ_IN2   (REQ_IN2),
        .GNT       (GNT),
        .OUT       (OUT),
        .OUT_CARRY (OUT_CARRY),
        .OUT_ID    (OUT_ID),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        REQ_IN1[i*W +: W] = a;
        REQ_IN2[i*W +: W] = b;
    endtask

    task automatic rr_ops();
        for (int i = 0; i < N; i++) set_ops(i, W'(i * 10), W'(i));
    endtask

    initial begin
        RST       = 1'b1;
        REQ       = N'($urandom);
        REQ_IN1   = '0;
        REQ_IN2   = '0;
        OUT_READY = 1'b0;
        rr_ops();

        // Reset with random requests
        tick();
        REQ = N'($urandom);
        tick();
        chk("rst_gnt", 32'(GNT), 0);
        chk("rst_out", 32'(OUT), 0);
        chk("rst_carry", 32'(OUT_CARRY), 0);
        chk("rst_id", 32'(OUT_ID), 0);
        chk("rst_valid", 32'(OUT_VALID), 0);
        chk("rst_busy", 32'(BUSY), 0);

        // First grant after reset goes to requester 0
        RST       = 1'b0;
        REQ       = 4'b1111;
        OUT_READY = 1'b1;
        tick();
        chk("first_gnt", 32'(GNT), 32'b0001);
        chk("first_busy", 32'(BUSY), 1);
        REQ = 4'b0000;
        tick();
        chk("first_out", 32'(OUT), 0);
        chk("first_valid", 32'(OUT_VALID), 1);
        tick();
        chk("first_done", 32'(OUT_VALID), 0);

        // Single request: 10 + 11
        set_ops(0, 16'd10, 16'd11);
        REQ = 4'b0001;
        tick();
        chk("single_gnt", 32'(GNT), 32'b0001);
        REQ = 4'b0000;
        tick();
        chk("single_gnt_off", 32'(GNT), 0);
        chk("single_out", 32'(OUT), 21);
        chk("single_carry", 32'(OUT_CARRY), 0);
        chk("single_id", 32'(OUT_ID), 0);
        chk("single_valid", 32'(OUT_VALID), 1);
        tick();
        chk("single_valid_off", 32'(OUT_VALID), 0);
        chk("single_idle", 32'(BUSY), 0);

        // Wrap: FFFF + 0002 from requester 2
        set_ops(2, 16'hFFFF, 16'h0002);
        REQ = 4'b0100;
        tick();
        chk("wrap_gnt", 32'(GNT), 32'b0100);
        REQ = 4'b0000;
        tick();
        chk("wrap_out", 32'(OUT), 32'h0001);
        chk("wrap_carry", 32'(OUT_CARRY), 1);
        chk("wrap_id", 32'(OUT_ID), 2);
        tick();

        // Round robin after a fresh reset, all four requesting
        RST = 1'b1;
        tick();
        RST = 1'b0;
        rr_ops();
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int id;
            id = k % N;
            tick();
            chk($sformatf("rr%0d_gnt", k), 32'(GNT), 32'(1 << id));
            if (k == 4) REQ = 4'b0000;
            tick();
            chk($sformatf("rr%0d_out", k), 32'(OUT), 32'(id * 11));
            chk($sformatf("rr%0d_id", k), 32'(OUT_ID), 32'(id));
            chk($sformatf("rr%0d_valid", k), 32'(OUT_VALID), 1);
            tick();
            chk($sformatf("rr%0d_gap", k), 32'(GNT), 0);
            chk($sformatf("rr%0d_vdone", k), 32'(OUT_VALID), 0);
        end

        // Backpressure on requester 1 (10 + 1), requester 2 waiting
        OUT_READY = 1'b0;
        REQ       = 4'b0010;
        tick();
        chk("bp_gnt", 32'(GNT), 32'b0010);
        REQ = 4'b0100;
        tick();
        chk("bp_out0", 32'(OUT), 11);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp%0d_out", c), 32'(OUT), 11);
            chk($sformatf("bp%0d_id", c), 32'(OUT_ID), 1);
            chk($sformatf("bp%0d_valid", c), 32'(OUT_VALID), 1);
            chk($sformatf("bp%0d_gnt", c), 32'(GNT), 0);
            chk($sformatf("bp%0d_busy", c), 32'(BUSY), 1);
        end
        OUT_READY = 1'b1;
        tick();
        chk("bp_release", 32'(OUT_VALID), 0);
        chk("bp_rel_gnt", 32'(GNT), 0);
        tick();
        chk("bp_next_gnt", 32'(GNT), 32'b0100);
        REQ       = 4'b0000;
        OUT_READY = 1'b0;
        tick();
        chk("mid_out", 32'(OUT), 22);
        chk("mid_id", 32'(OUT_ID), 2);
        chk("mid_valid", 32'(OUT_VALID), 1);

        // Reset while holding the result for requester 2
        RST = 1'b1;
        REQ = 4'b1111;
        tick();
        chk("mid_rst_valid", 32'(OUT_VALID), 0);
        chk("mid_rst_out", 32'(OUT), 0);
        chk("mid_rst_id", 32'(OUT_ID), 0);
        chk("mid_rst_busy", 32'(BUSY), 0);
        RST = 1'b0;
        tick();
        chk("mid_rst_gnt", 32'(GNT), 32'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
